// File: rtl/rr_arb5_8b.sv
// rr_arb5_8b: five-source round-robin arbiter feeding a one-entry output register.
// Grants are combinational from the last-granted pointer, the request vector and
// whether the output stage can take a word this cycle. The granted byte is
// registered with a valid/ready handshake, so one word per cycle can move when
// the consumer keeps out_ready high.
// Optional feature macro: ARB5_CNT_EN adds xfer_cnt, a wrapping count of words
// accepted by the consumer.
module rr_arb5_8b #(
    parameter int DW = 8
`ifdef ARB5_CNT_EN
    ,
    parameter int CNTW = 16
`endif
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [4:0]    req,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [DW-1:0] in4,
    output logic [4:0]    ack,
    output logic [2:0]    sel,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_src,
    input  logic          out_ready
`ifdef ARB5_CNT_EN
    ,
    output logic [CNTW-1:0] xfer_cnt
`endif
);

    // Index 0..4 plus offset 1..5, reduced mod 5.
    function automatic logic [2:0] wrap_add(input logic [2:0] p, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, off};
        if (s >= 4'd10)
            return 3'(s - 4'd10);
        else if (s >= 4'd5)
            return 3'(s - 4'd5);
        else
            return s[2:0];
    endfunction

    // Registered state. EMPTY/FULL is encoded by out_valid_q alone.
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [2:0]    out_src_q,   out_src_d;
    logic [2:0]    ptr_q,       ptr_d;

    logic          can_load;
    logic          any_hit;
    logic [2:0]    win_idx;
    logic          grant;
    logic          accept;
    logic [DW-1:0] win_data;

    assign can_load = !out_valid_q || out_ready;
    assign accept   = out_valid_q && out_ready;

    // Round-robin search: first requester after the last winner.
    always_comb begin
        any_hit = 1'b0;
        win_idx = 3'd0;
        for (int off = 1; off <= 5; off++) begin
            logic [2:0] cand;
            cand = wrap_add(ptr_q, 3'(off));
            if (!any_hit && req[cand]) begin
                any_hit = 1'b1;
                win_idx = cand;
            end
        end
    end

    // No grant while in reset or while the output stage is stalled.
    assign grant = resetn && can_load && any_hit;

    // One-hot ack and mux select; 7 marks "nothing granted".
    always_comb begin
        ack = 5'b0;
        sel = 3'd7;
        if (grant) begin
            ack = 5'b00001 << win_idx;
            sel = win_idx;
        end
    end

    // Downstream 5:1 byte mux driven by the grant index.
    always_comb begin
        case (win_idx)
            3'd0:    win_data = in0;
            3'd1:    win_data = in1;
            3'd2:    win_data = in2;
            3'd3:    win_data = in3;
            3'd4:    win_data = in4;
            default: win_data = '0;
        endcase
    end

    // Next state: a grant reloads the stage (even while the old word is accepted),
    // an accept without grant empties it, a stall holds everything.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_src_d   = win_idx;
            ptr_d       = win_idx;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; ptr resets to 4 so the first search starts at source 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 3'd0;
            ptr_q       <= 3'd4;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef ARB5_CNT_EN
    logic [CNTW-1:0] xfer_cnt_q, xfer_cnt_d;

    assign xfer_cnt_d = accept ? xfer_cnt_q + 1'b1 : xfer_cnt_q;

    // Accepted-word counter, wraps naturally at 2^CNTW.
    always_ff @(posedge clk) begin
        if (!resetn)
            xfer_cnt_q <= '0;
        else
            xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb5_8b.sv
// Bench for rr_arb5_8b: directed vector table, random run against a
// round-robin reference model, and (with ARB5_CNT_EN) a long counter wrap run.
module tb_rr_arb5_8b;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] req;
    logic [7:0] in0, in1, in2, in3, in4;
    logic [4:0] ack;
    logic [2:0] sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_src;
    logic       out_ready;
`ifdef ARB5_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    rr_arb5_8b dut (
        .clk(clk), .resetn(resetn), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .ack(ack), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
`ifdef ARB5_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic       rst_n;
        logic [4:0] rq;
        logic       rdy;
        logic [4:0] e_ack;
        logic [2:0] e_sel;
        logic       e_vld;
        logic [7:0] e_data;
        logic [2:0] e_src;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [4:0] q, logic y, logic [4:0] a,
                                logic [2:0] s, logic v, logic [7:0] d, logic [2:0] o);
        vec_t x;
        x.rst_n = r; x.rq = q; x.rdy = y; x.e_ack = a; x.e_sel = s;
        x.e_vld = v; x.e_data = d; x.e_src = o;
        return x;
    endfunction

    // Reference: winner is the first requester strictly after the last winner, mod 5.
    function automatic int pick(int last, logic [4:0] r);
        for (int off = 1; off <= 5; off++) begin
            int k;
            k = (last + off) % 5;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // Model state for the random phase
    bit       m_vld;
    bit [7:0] m_data;
    int       m_src;
    int       m_last;
    int       m_cnt;

    initial begin
        resetn = 1'b0; req = '0; out_ready = 1'b1;
        in0 = 8'hA0; in1 = 8'hA1; in2 = 8'hA2; in3 = 8'hA3; in4 = 8'hA4;

        // Full rotation with all requesting
        vt.push_back(mk(0, 5'h1F, 1, 5'h00, 7, 0, 8'h00, 0));
        vt.push_back(mk(1, 5'h1F, 1, 5'h01, 0, 1, 8'hA0, 0));
        vt.push_back(mk(1, 5'h1F, 1, 5'h02, 1, 1, 8'hA1, 1));
        vt.push_back(mk(1, 5'h1F, 1, 5'h04, 2, 1, 8'hA2, 2));
        vt.push_back(mk(1, 5'h1F, 1, 5'h08, 3, 1, 8'hA3, 3));
        vt.push_back(mk(1, 5'h1F, 1, 5'h10, 4, 1, 8'hA4, 4));
        vt.push_back(mk(1, 5'h1F, 1, 5'h01, 0, 1, 8'hA0, 0));
        // Stall after first capture, then release loads A1 at the accept edge
        vt.push_back(mk(0, 5'h1F, 1, 5'h00, 7, 0, 8'h00, 0));
        vt.push_back(mk(1, 5'h1F, 0, 5'h01, 0, 1, 8'hA0, 0));
        vt.push_back(mk(1, 5'h1F, 0, 5'h00, 7, 1, 8'hA0, 0));
        vt.push_back(mk(1, 5'h1F, 0, 5'h00, 7, 1, 8'hA0, 0));
        vt.push_back(mk(1, 5'h1F, 0, 5'h00, 7, 1, 8'hA0, 0));
        vt.push_back(mk(1, 5'h1F, 1, 5'h02, 1, 1, 8'hA1, 1));
        // Sparse requests 1 and 4 alternate
        vt.push_back(mk(0, 5'h12, 1, 5'h00, 7, 0, 8'h00, 0));
        vt.push_back(mk(1, 5'h12, 1, 5'h02, 1, 1, 8'hA1, 1));
        vt.push_back(mk(1, 5'h12, 1, 5'h10, 4, 1, 8'hA4, 4));
        vt.push_back(mk(1, 5'h12, 1, 5'h02, 1, 1, 8'hA1, 1));
        vt.push_back(mk(1, 5'h12, 1, 5'h10, 4, 1, 8'hA4, 4));
        // Reset while full and stalled; restart grants source 0
        vt.push_back(mk(1, 5'h1F, 0, 5'h00, 7, 1, 8'hA4, 4));
        vt.push_back(mk(0, 5'h1F, 0, 5'h00, 7, 0, 8'h00, 0));
        vt.push_back(mk(1, 5'h1F, 0, 5'h01, 0, 1, 8'hA0, 0));
        // Accept with no request empties the stage, data unchanged
        vt.push_back(mk(1, 5'h00, 1, 5'h00, 7, 0, 8'hA0, 0));

        foreach (vt[i]) begin
            @(negedge clk);
            resetn = vt[i].rst_n; req = vt[i].rq; out_ready = vt[i].rdy;
            #1;
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(vt[i].e_ack));
            chk($sformatf("v%0d sel", i), 32'(sel), 32'(vt[i].e_sel));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_vld));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].e_data));
            chk($sformatf("v%0d out_src", i), 32'(out_src), 32'(vt[i].e_src));
        end

        // Random phase against the reference model; first cycle forces reset
        for (int c = 0; c < 2000; c++) begin
            logic [7:0] din [5];
            int  g;
            bit  gnt;
            logic [4:0] eack;
            logic [2:0] esel;
            @(negedge clk);
            resetn    = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            req       = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
            in3 = 8'($urandom); in4 = 8'($urandom);
            din[0] = in0; din[1] = in1; din[2] = in2; din[3] = in3; din[4] = in4;
            g    = pick(m_last, req);
            gnt  = resetn && (!m_vld || out_ready) && (g >= 0);
            eack = gnt ? 5'(1 << g) : 5'h00;
            esel = gnt ? 3'(g) : 3'd7;
            #1;
            chk("rnd ack", 32'(ack), 32'(eack));
            chk("rnd sel", 32'(sel), 32'(esel));
            @(posedge clk);
            if (!resetn) begin
                m_vld = 0; m_data = 0; m_src = 0; m_last = 4; m_cnt = 0;
            end else begin
                if (m_vld && out_ready) m_cnt = (m_cnt + 1) % 65536;
                if (gnt) begin
                    m_vld = 1; m_data = din[g]; m_src = g; m_last = g;
                end else if (m_vld && out_ready) begin
                    m_vld = 0;
                end
            end
            #1;
            chk("rnd out_valid", 32'(out_valid), 32'(m_vld));
            chk("rnd out_data", 32'(out_data), 32'(m_data));
            chk("rnd out_src", 32'(out_src), 32'(m_src));
`ifdef ARB5_CNT_EN
            chk("rnd xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
        end

`ifdef ARB5_CNT_EN
        // 70000 accepted words with periodic stalls; count wraps to 70000-65536
        begin
            int  acc;
            int  i;
            bit  mv;
            @(negedge clk); resetn = 1'b0; req = 5'h1F; out_ready = 1'b1;
            @(posedge clk);
            acc = 0; i = 0; mv = 0;
            while (acc < 70000) begin
                @(negedge clk);
                resetn = 1'b1;
                out_ready = (i % 16 == 5) ? 1'b0 : 1'b1;
                i++;
                @(posedge clk);
                if (mv && out_ready) acc++;
                mv = 1;
            end
            #1;
            chk("cnt wrap", 32'(xfer_cnt), 32'(70000 % 65536));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
